// File: rtl/cnn_pkg.sv
// Shared pixel type and window indexing helper for the CNN streaming front end.
package cnn_pkg;

   localparam int DATA_W = 16;

   typedef logic [DATA_W-1:0] pixel_t;

   // Flat row-major position of window element (i,j) for a ws x ws kernel.
   function automatic int win_index(input int i, input int j, input int ws = 3);
      return i * ws + j;
   endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of pixel storage; a shift writes the new pixel at a column
// while the previous occupant of that column is presented on dout.
module line_buffer
   import cnn_pkg::*;
#(
   parameter int IMG_WIDTH = 28,
   parameter int DATA_W    = cnn_pkg::DATA_W,
   parameter int AW        = $clog2(IMG_WIDTH)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              shift,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem_reg [IMG_WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < IMG_WIDTH; k++) begin
            mem_reg[k] <= '0;
         end
      end else if (shift) begin
         mem_reg[addr] <= din;
      end
   end

   assign dout = mem_reg[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Sliding WINDOW_SIZE x WINDOW_SIZE window generator over a raster pixel stream.
// Define WIN_STRIDE2_EN to emit only windows whose origin row and column are even.
module conv_window_gen
   import cnn_pkg::*;
#(
   parameter int WINDOW_SIZE = 3,
   parameter int IMG_WIDTH   = 28,
   parameter int IMG_HEIGHT  = 28,
   parameter int DATA_W      = cnn_pkg::DATA_W
)(
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [DATA_W-1:0]                         in_pixel,
   input  logic                                      in_sof,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   output logic [WINDOW_SIZE*WINDOW_SIZE*DATA_W-1:0] win_data,
   output logic                                      win_valid,
   input  logic                                      win_ready,
   output logic                                      frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(WINDOW_SIZE - 1);
   localparam logic [RW-1:0] ROW_WIN  = RW'(WINDOW_SIZE - 1);

   logic [CW-1:0] col_reg;
   logic [CW-1:0] col_eff;
   logic [RW-1:0] row_reg;
   logic [RW-1:0] row_eff;
   logic          accept;
   logic          forms;
   logic          last_px;
   logic          win_valid_reg;
   logic          frame_done_reg;

   logic [DATA_W-1:0] lb_din [WINDOW_SIZE-1];
   logic [DATA_W-1:0] lb_out [WINDOW_SIZE-1];
   logic [DATA_W-1:0] col_in [WINDOW_SIZE];

   assign in_ready   = !win_valid_reg || win_ready;
   assign accept     = in_valid && in_ready;
   assign win_valid  = win_valid_reg;
   assign frame_done = frame_done_reg;

   // A start-of-frame pixel is always (0,0), whatever the counters say.
   assign col_eff = in_sof ? '0 : col_reg;
   assign row_eff = in_sof ? '0 : row_reg;
   assign last_px = (row_eff == ROW_LAST) && (col_eff == COL_LAST);

`ifdef WIN_STRIDE2_EN
   // Origin (r-WS+1) is even exactly when r has the parity of WS-1.
   localparam logic PAR = 1'((WINDOW_SIZE - 1) % 2);
   assign forms = (row_eff >= ROW_WIN) && (col_eff >= COL_WIN)
                  && (row_eff[0] == PAR) && (col_eff[0] == PAR);
`else
   assign forms = (row_eff >= ROW_WIN) && (col_eff >= COL_WIN);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (accept) begin
         if (col_eff == COL_LAST) begin
            col_reg <= '0;
            row_reg <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
         end else begin
            col_reg <= col_eff + CW'(1);
            row_reg <= row_eff;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= accept && last_px;
         if (accept && forms) begin
            win_valid_reg <= 1'b1;
         end else if (win_ready) begin
            win_valid_reg <= 1'b0;
         end
      end
   end

   // Line buffers chained vertically: buffer 0 holds the previous row.
   genvar gi;
   generate
      for (gi = 0; gi < WINDOW_SIZE - 1; gi++) begin : lb_g
         if (gi == 0) begin : first_g
            assign lb_din[gi] = in_pixel;
         end else begin : chain_g
            assign lb_din[gi] = lb_out[gi-1];
         end

         line_buffer #(
            .IMG_WIDTH (IMG_WIDTH),
            .DATA_W    (DATA_W),
            .AW        (CW)
         ) u_line_buffer (
            .clk   (clk),
            .reset (reset),
            .shift (accept),
            .addr  (col_eff),
            .din   (lb_din[gi]),
            .dout  (lb_out[gi])
         );
      end

      // New right-hand column, oldest row on top, incoming pixel at the bottom.
      for (gi = 0; gi < WINDOW_SIZE; gi++) begin : col_g
         if (gi == WINDOW_SIZE - 1) begin : bottom_g
            assign col_in[gi] = in_pixel;
         end else begin : upper_g
            assign col_in[gi] = lb_out[WINDOW_SIZE-2-gi];
         end
      end

      // Each window row shifts toward element 0; only accepts move it, which
      // keeps win_data frozen while a window is stalled.
      for (gi = 0; gi < WINDOW_SIZE; gi++) begin : row_g
         logic [WINDOW_SIZE*DATA_W-1:0] win_row_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               win_row_reg <= '0;
            end else if (accept) begin
               win_row_reg <= {col_in[gi], win_row_reg[WINDOW_SIZE*DATA_W-1:DATA_W]};
            end
         end

         assign win_data[win_index(gi, 0, WINDOW_SIZE)*DATA_W +: WINDOW_SIZE*DATA_W] = win_row_reg;
      end
   endgenerate

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: table-driven first frame, then stall, back-to-back,
// sof-abort and mid-frame reset sequences, all checked through a window scoreboard.
module tb_conv_window_gen;
   import cnn_pkg::*;

   localparam int WS = 3;
`ifdef WIN_STRIDE2_EN
   localparam int W  = 6;
   localparam int H  = 6;
   localparam bit S2 = 1'b1;
`else
   localparam int W  = 4;
   localparam int H  = 4;
   localparam bit S2 = 1'b0;
`endif
   localparam int NWIN  = S2 ? ((H - WS + 2) / 2) * ((W - WS + 2) / 2)
                             : (H - WS + 1) * (W - WS + 1);
   localparam int WB    = WS * WS * 16;
   localparam int FIRST = (WS - 1) * W + (WS - 1);

   typedef logic [WB-1:0] win_t;

   typedef struct {
      int   pix;
      bit   sof;
      bit   exp_valid;
      win_t exp_win;
      bit   exp_fd;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_pixel;
   logic        in_sof;
   logic        in_valid;
   logic        in_ready;
   win_t        win_data;
   logic        win_valid;
   logic        win_ready;
   logic        frame_done;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     win_cnt = 0;
   int     fd_cnt = 0;
   win_t   exp_q[$];
   pixel_t img [H][W];
   int     mr = 0;
   int     mc = 0;

   conv_window_gen #(
      .WINDOW_SIZE (WS),
      .IMG_WIDTH   (W),
      .IMG_HEIGHT  (H),
      .DATA_W      (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_pixel   (in_pixel),
      .in_sof     (in_sof),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .win_data   (win_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input win_t act, input win_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic win_t mkwin(input int base, input int r0, input int c0);
      win_t w;
      w = '0;
      for (int i = 0; i < WS; i++) begin
         for (int j = 0; j < WS; j++) begin
            w[(i*WS+j)*16 +: 16] = 16'(base + (r0 + i) * W + (c0 + j));
         end
      end
      return w;
   endfunction

   // Reference model: tracks image position and queues every window it should form.
   task automatic model_accept(input int p, input bit s);
      win_t w;
      if (s) begin
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = 16'(p);
      if (mr >= WS - 1 && mc >= WS - 1 &&
          (!S2 || (((mr - WS + 1) % 2 == 0) && ((mc - WS + 1) % 2 == 0)))) begin
         w = '0;
         for (int i = 0; i < WS; i++) begin
            for (int j = 0; j < WS; j++) begin
               w[(i*WS+j)*16 +: 16] = img[mr-WS+1+i][mc-WS+1+j];
            end
         end
         exp_q.push_back(w);
      end
      if (mc == W - 1) begin
         mc = 0;
         mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send(input int p, input bit s);
      int n;
      n = 0;
      in_pixel = 16'(p);
      in_sof   = s;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: in_ready got 0 required 1 for pixel %0d", p);
      end else begin
         model_accept(p, s);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard side: every handshaken window is popped and compared.
   always @(negedge clk) begin
      #1;
      if (!reset && win_valid && win_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_window: got %h required none", win_data);
         end else begin
            check("window", win_data, exp_q.pop_front());
         end
         win_cnt++;
      end
      if (frame_done) fd_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation got no end required finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl [W*H];
      int   w0;
      int   f0;
      int   r;
      int   c;

      for (int k = 0; k < W * H; k++) begin
         r = k / W;
         c = k % W;
         tbl[k].pix       = k + 1;
         tbl[k].sof       = (k == 0);
         tbl[k].exp_valid = (r >= WS - 1) && (c >= WS - 1) &&
                            (!S2 || (((r - WS + 1) % 2 == 0) && ((c - WS + 1) % 2 == 0)));
         tbl[k].exp_win   = tbl[k].exp_valid ? mkwin(1, r - WS + 1, c - WS + 1) : '0;
         tbl[k].exp_fd    = (k == W * H - 1);
      end

      reset     = 1'b1;
      win_ready = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_pixel  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_win_valid", win_t'(win_valid), '0);
      check("rst_win_data", win_data, '0);
      check("rst_frame_done", win_t'(frame_done), '0);
      check("rst_in_ready", win_t'(in_ready), win_t'(1));
      @(negedge clk);

      // Table-driven first frame with the sink always ready.
      w0 = win_cnt;
      f0 = fd_cnt;
      for (int k = 0; k < W * H; k++) begin
         send(tbl[k].pix, tbl[k].sof);
         #1;
         check($sformatf("t1_valid_px%0d", tbl[k].pix), win_t'(win_valid), win_t'(tbl[k].exp_valid));
         if (tbl[k].exp_valid) check($sformatf("t1_data_px%0d", tbl[k].pix), win_data, tbl[k].exp_win);
         check($sformatf("t1_fd_px%0d", tbl[k].pix), win_t'(frame_done), win_t'(tbl[k].exp_fd));
      end
      idle(3);
      check("t1_windows", win_t'(win_cnt - w0), win_t'(NWIN));
      check("t1_frame_done", win_t'(fd_cnt - f0), win_t'(1));

      // Stall the first window and make sure the stream backs up intact.
      w0 = win_cnt;
      f0 = fd_cnt;
      for (int k = 0; k <= FIRST; k++) send(k + 1, k == 0);
      win_ready = 1'b0;
      fork
         begin
            for (int k = FIRST + 1; k < W * H; k++) send(k + 1, 1'b0);
         end
         begin
            repeat (4) begin
               #1;
               check("t2_stall_in_ready", win_t'(in_ready), '0);
               check("t2_stall_valid", win_t'(win_valid), win_t'(1));
               check("t2_stall_data", win_data, mkwin(1, 0, 0));
               @(negedge clk);
            end
            win_ready = 1'b1;
         end
      join
      idle(3);
      check("t2_windows", win_t'(win_cnt - w0), win_t'(NWIN));
      check("t2_frame_done", win_t'(fd_cnt - f0), win_t'(1));

      // Two frames with no gap between them.
      w0 = win_cnt;
      f0 = fd_cnt;
      for (int k = 0; k < W * H; k++) send(1 + k, k == 0);
      for (int k = 0; k < W * H; k++) begin
         send(101 + k, k == 0);
         if (k == FIRST) begin
            #1;
            check("t3_frame2_first", win_data, mkwin(101, 0, 0));
         end
      end
      idle(3);
      check("t3_windows", win_t'(win_cnt - w0), win_t'(2 * NWIN));
      check("t3_frame_done", win_t'(fd_cnt - f0), win_t'(2));

      // Partial frame abandoned by a new start-of-frame.
      w0 = win_cnt;
      f0 = fd_cnt;
      for (int k = 0; k < 7; k++) send(1 + k, k == 0);
      for (int k = 0; k < W * H; k++) send(101 + k, k == 0);
      idle(3);
      check("t4_windows", win_t'(win_cnt - w0), win_t'(NWIN));
      check("t4_frame_done", win_t'(fd_cnt - f0), win_t'(1));

      // Reset while a window is pending, then a frame without sof.
      for (int k = 0; k <= FIRST; k++) send(1 + k, k == 0);
      win_ready = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      #1;
      check("t5_rst_valid", win_t'(win_valid), '0);
      check("t5_rst_data", win_data, '0);
      reset = 1'b0;
      exp_q.delete();
      mr = 0;
      mc = 0;
      win_ready = 1'b1;
      @(negedge clk);
      w0 = win_cnt;
      f0 = fd_cnt;
      for (int k = 0; k < W * H; k++) send(1 + k, 1'b0);
      idle(3);
      check("t5_windows", win_t'(win_cnt - w0), win_t'(NWIN));
      check("t5_frame_done", win_t'(fd_cnt - f0), win_t'(1));
      check("scoreboard_empty", win_t'(exp_q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
